// File: rtl/frame_generator.sv
// Serial frame transmitter: 8-bit sync word plus counting payload, MSB first, one bit per clock.
// Optional payload scrambling (PN9, x^9+x^5+1) is built when FRAME_GEN_SCRAMBLE_EN is defined.
module frame_generator #(
  parameter logic [7:0] SYNC_WORD   = 8'b10011011,
  parameter int         FRAME_BYTES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] mode,
  output logic       sdata,
  output logic       bit_valid,
  output logic       frame_start,
  output logic       sync_bit,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

  localparam logic [7:0] LAST_BIT = 8'(FRAME_BYTES * 8 - 1);

  state_t     state_reg, state_next;
  logic [7:0] bit_idx_reg, bit_idx_next;
  logic [7:0] frame_idx_reg, frame_idx_next;
  logic [1:0] mode_reg, mode_next;
  logic [7:0] frame_cnt_reg, frame_cnt_next;
  logic       sdata_reg, sdata_next;
  logic       valid_reg, valid_next;
  logic       fstart_reg, fstart_next;
  logic       sync_reg, sync_next;

  logic [1:0] cur_mode;
  logic       drop_sync;
  logic [7:0] pay_byte;
  logic       plain_bit;

`ifdef FRAME_GEN_SCRAMBLE_EN
  logic [8:0] pn_reg, pn_next;
`endif

  // bit_idx/frame_idx name the next bit to send; mode is taken live only for bit 0.
  always_comb begin
    cur_mode  = (bit_idx_reg == 8'd0) ? mode : mode_reg;
    drop_sync = 1'b0;
    case (cur_mode)
      2'b10:   drop_sync = (frame_idx_reg[2:0] == 3'b111);
      2'b11:   drop_sync = (frame_idx_reg[3:0] >= 4'd12);
      default: drop_sync = 1'b0;
    endcase
    pay_byte  = (cur_mode == 2'b01) ? 8'h00
              : frame_idx_reg + {3'b000, bit_idx_reg[7:3]} - 8'd1;
    plain_bit = pay_byte[3'd7 - bit_idx_reg[2:0]];
  end

  always_comb begin
    state_next     = state_reg;
    bit_idx_next   = bit_idx_reg;
    frame_idx_next = frame_idx_reg;
    mode_next      = mode_reg;
    frame_cnt_next = frame_cnt_reg;
    sdata_next     = 1'b0;
    valid_next     = 1'b0;
    fstart_next    = 1'b0;
    sync_next      = 1'b0;
`ifdef FRAME_GEN_SCRAMBLE_EN
    pn_next        = pn_reg;
`endif
    if (enable) begin
      valid_next     = 1'b1;
      fstart_next    = (bit_idx_reg == 8'd0);
      frame_cnt_next = frame_idx_reg;
      mode_next      = cur_mode;
      if (state_reg != DATA) begin
        sdata_next = drop_sync ? 1'b0 : SYNC_WORD[3'd7 - bit_idx_reg[2:0]];
        sync_next  = ~drop_sync;
`ifdef FRAME_GEN_SCRAMBLE_EN
        if (bit_idx_reg == 8'd0)
          pn_next = 9'h1FF;
`endif
      end else begin
`ifdef FRAME_GEN_SCRAMBLE_EN
        sdata_next = plain_bit ^ pn_reg[8];
        pn_next    = {pn_reg[7:0], pn_reg[8] ^ pn_reg[4]};
`else
        sdata_next = plain_bit;
`endif
      end
      case (state_reg)
        IDLE, SYNC: begin
          bit_idx_next = bit_idx_reg + 8'd1;
          state_next   = (bit_idx_reg == 8'd7) ? DATA : SYNC;
        end
        DATA: begin
          if (bit_idx_reg == LAST_BIT) begin
            bit_idx_next   = 8'd0;
            frame_idx_next = frame_idx_reg + 8'd1;
            state_next     = SYNC;
          end else begin
            bit_idx_next = bit_idx_reg + 8'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      bit_idx_reg   <= 8'd0;
      frame_idx_reg <= 8'd0;
      mode_reg      <= 2'b00;
      frame_cnt_reg <= 8'd0;
      sdata_reg     <= 1'b0;
      valid_reg     <= 1'b0;
      fstart_reg    <= 1'b0;
      sync_reg      <= 1'b0;
`ifdef FRAME_GEN_SCRAMBLE_EN
      pn_reg        <= 9'h1FF;
`endif
    end else begin
      state_reg     <= state_next;
      bit_idx_reg   <= bit_idx_next;
      frame_idx_reg <= frame_idx_next;
      mode_reg      <= mode_next;
      frame_cnt_reg <= frame_cnt_next;
      sdata_reg     <= sdata_next;
      valid_reg     <= valid_next;
      fstart_reg    <= fstart_next;
      sync_reg      <= sync_next;
`ifdef FRAME_GEN_SCRAMBLE_EN
      pn_reg        <= pn_next;
`endif
    end
  end

  assign sdata       = sdata_reg;
  assign bit_valid   = valid_reg;
  assign frame_start = fstart_reg;
  assign sync_bit    = sync_reg;
  assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_frame_generator.sv
// Scoreboarded bench for frame_generator: a cycle model queues the expected outputs for each edge,
// plus directed checks on captured sync/payload bytes and frame_start spacing.
module tb_frame_generator;

  localparam int FB = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       sdata, bit_valid, frame_start, sync_bit;
  logic [7:0] frame_cnt;

  frame_generator #(.SYNC_WORD(8'b10011011), .FRAME_BYTES(FB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .sdata(sdata), .bit_valid(bit_valid), .frame_start(frame_start),
    .sync_bit(sync_bit), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  // reference model state
  int         m_pos = 0;
  logic [7:0] m_frame = 8'd0;
  logic [1:0] m_mode = 2'b00;
  logic [7:0] m_cnt_out = 8'd0;
  logic [8:0] m_pn = 9'h1FF;

  // observation state
  int         cyc = 0;
  int         obs_pos = 0;
  int         last_fs = -1;
  int         fs_period = 0;
  logic [7:0] fs_cnt = 8'd0;
  logic [7:0] sh = 8'd0;
  logic [7:0] cap0 = 8'd0, cap1 = 8'd0, cap2 = 8'd0;
  logic [8:0] first9 = 9'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic [11:0] e, o;
    logic [7:0]  sw, byte_v;
    logic        b, s, drop;
    sw = 8'h9B;
    if (reset) begin
      e = 12'h000; m_pos = 0; m_frame = 8'd0; m_cnt_out = 8'd0;
    end else if (!enable) begin
      e = {4'b0000, m_cnt_out};
    end else begin
      if (m_pos == 0) begin m_mode = mode; m_pn = 9'h1FF; end
      if (m_pos < 8) begin
        drop = (m_mode == 2'b10 && (m_frame % 8) == 7) || (m_mode == 2'b11 && (m_frame % 16) >= 12);
        b = drop ? 1'b0 : sw[7 - m_pos];
        s = ~drop;
      end else begin
        byte_v = (m_mode == 2'b01) ? 8'h00 : m_frame + 8'(m_pos / 8) - 8'd1;
        b = byte_v[7 - (m_pos % 8)];
`ifdef FRAME_GEN_SCRAMBLE_EN
        b = b ^ m_pn[8];
        m_pn = {m_pn[7:0], m_pn[8] ^ m_pn[4]};
`endif
        s = 1'b0;
      end
      m_cnt_out = m_frame;
      e = {b, 1'b1, (m_pos == 0), s, m_frame};
      m_pos++;
      if (m_pos == FB * 8) begin m_pos = 0; m_frame = m_frame + 8'd1; end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    o = {sdata, bit_valid, frame_start, sync_bit, frame_cnt};
    check($sformatf("cycle%0d", cyc), 32'(o), 32'(exp_q.pop_front()));
    if (bit_valid === 1'b1) begin
      if (frame_start === 1'b1) begin
        obs_pos = 0;
        if (last_fs >= 0) fs_period = cyc - last_fs;
        last_fs = cyc;
        fs_cnt = frame_cnt;
        $display("frame %0d start at cycle %0d mode %b", frame_cnt, cyc, mode);
      end else begin
        obs_pos++;
      end
      sh = {sh[6:0], sdata};
      if (obs_pos >= 8 && obs_pos <= 16) first9 = {first9[7:0], sdata};
      if (obs_pos == 7)  cap0 = sh;
      if (obs_pos == 15) cap1 = sh;
      if (obs_pos == 23) cap2 = sh;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    last_fs = -1;
  endtask

  initial begin
    // 1: normal mode, first frames
    do_reset();
    check("reset_outs", 32'({sdata, bit_valid, frame_start, sync_bit, frame_cnt}), 32'h0);
    mode = 2'b00; enable = 1'b1;
    repeat (24) tick();
    check("f0_sync", 32'(cap0), 32'h9B);
`ifndef FRAME_GEN_SCRAMBLE_EN
    check("f0_byte1", 32'(cap1), 32'h00);
    check("f0_byte2", 32'(cap2), 32'h01);
`endif
    repeat (256) tick();
    check("f1_period", 32'(fs_period), 32'd256);
    check("f1_cnt", 32'(fs_cnt), 32'd1);
`ifndef FRAME_GEN_SCRAMBLE_EN
    check("f1_byte1", 32'(cap1), 32'h01);
`endif

    // 2: drop one sync in eight
    do_reset();
    mode = 2'b10; enable = 1'b1;
    for (int f = 0; f < 16; f++) begin
      repeat (256) tick();
      check($sformatf("m10_sync_f%0d", f), 32'(cap0), (f % 8 == 7) ? 32'h00 : 32'h9B);
    end
    check("m10_period", 32'(fs_period), 32'd256);

    // 3: drop four syncs in sixteen
    do_reset();
    mode = 2'b11; enable = 1'b1;
    for (int f = 0; f < 32; f++) begin
      repeat (256) tick();
      check($sformatf("m11_sync_f%0d", f), 32'(cap0), (f % 16 >= 12) ? 32'h00 : 32'h9B);
    end

    // 4: pause 5 cycles at bit 100 of frame 2
    do_reset();
    mode = 2'b00; enable = 1'b1;
    repeat (2 * 256 + 100) tick();
    enable = 1'b0;
    repeat (5) tick();
    check("pause_valid", 32'(bit_valid), 32'd0);
    enable = 1'b1;
    repeat (256 - 100 + 1) tick();
    check("pause_period", 32'(fs_period), 32'd261);
    check("pause_cnt", 32'(fs_cnt), 32'd3);

    // 5: mode change mid-frame, then reset mid-frame
    do_reset();
    mode = 2'b00; enable = 1'b1;
    repeat (3 * 256 + 50) tick();
    mode = 2'b01;
    repeat (256 - 50) tick();
`ifndef FRAME_GEN_SCRAMBLE_EN
    check("f3_byte1_plain", 32'(cap1), 32'h03);
`endif
    repeat (120) tick();
    check("f4_cnt", 32'(fs_cnt), 32'd4);
`ifndef FRAME_GEN_SCRAMBLE_EN
    check("f4_byte1_zero", 32'(cap1), 32'h00);
`endif
    reset = 1'b1;
    tick();
    check("midrst_outs", 32'({sdata, bit_valid, frame_start, sync_bit, frame_cnt}), 32'h0);
    reset = 1'b0;
    last_fs = -1;
    repeat (8) tick();
    check("restart_sync", 32'(cap0), 32'h9B);
    check("restart_cnt", 32'(fs_cnt), 32'd0);

`ifdef FRAME_GEN_SCRAMBLE_EN
    // 6: scrambled zero payload
    do_reset();
    mode = 2'b01; enable = 1'b1;
    repeat (17) tick();
    check("scr_sync", 32'(cap0), 32'h9B);
    check("scr_first9", 32'(first9), 32'h1FF);
    repeat (256) tick();
    check("scr_first9_f1", 32'(first9), 32'h1FF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
